// File: rtl/mssv_pkg.sv
// Shared ID-digit definitions for the counter/transfer chain.
// Both the transmitter and the receive-side checker index this one table.
package mssv_pkg;

  localparam int ID_LEN  = 8;
  localparam int DIGIT_W = 4;
  localparam int POS_W   = 3;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [POS_W-1:0]   pos_t;

  localparam digit_t MSSV_DIGITS [ID_LEN] = '{
    4'd1, 4'd8, 4'd5, 4'd2, 4'd1, 4'd5, 4'd2, 4'd2
  };

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

endpackage

// File: rtl/mssv_digit_rom.sv
// Position -> expected ID digit lookup, purely combinational.
module mssv_digit_rom
  import mssv_pkg::*;
(
  input  logic [POS_W-1:0]   pos,
  output logic [DIGIT_W-1:0] digit
);

  assign digit = MSSV_DIGITS[pos];

endmodule

// File: rtl/mssv_seq_checker.sv
// Receive-side ID sequence checker: tracks position in the 8-digit ID,
// flags full matches and loss of sync, and counts matches with saturation.
module mssv_seq_checker
  import mssv_pkg::*;
#(
  parameter int unsigned CNT_W         = 8,
  parameter bit          LOCK_ON_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [3:0]         digit_i,
  input  logic               load_i,
  input  logic [2:0]         value_i,
  output logic [2:0]         pos_o,
  output logic [3:0]         expected_o,
  output logic               match_o,
  output logic               error_o,
  output logic               lock_o,
  output logic [CNT_W-1:0]   match_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_next_s;
  pos_t             pos_r, pos_next_s;
  logic             match_r, match_next_s;
  logic             error_r, error_next_s;
  logic             consec_r, consec_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  digit_t           exp_digit_s;

  mssv_digit_rom u_rom (
    .pos   (pos_r),
    .digit (exp_digit_s)
  );

  // Next-state, fallback position and output pulse decode.
  always_comb begin
    state_next_s  = state_r;
    pos_next_s    = pos_r;
    match_next_s  = 1'b0;
    error_next_s  = 1'b0;
    consec_next_s = consec_r;
    cnt_next_s    = cnt_r;
    if (load_i) begin
      pos_next_s = value_i;
    end else if (valid_i) begin
      if (digit_i == exp_digit_s) begin
        pos_next_s = pos_r + 3'd1;
        if (pos_r == 3'd7) begin
          match_next_s  = 1'b1;
          consec_next_s = 1'b1;
          cnt_next_s    = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
          if (LOCK_ON_FIRST || consec_r) begin
            state_next_s = LOCK;
          end else begin
            state_next_s = state_r;
          end
        end else begin
          match_next_s = 1'b0;
        end
      end else begin
        // A mismatch may still be the start of a fresh ID ("1" or "18").
        if ((pos_r == 3'd5) && (digit_i == 4'd8)) begin
          pos_next_s = 3'd2;
        end else if (digit_i == 4'd1) begin
          pos_next_s = 3'd1;
        end else begin
          pos_next_s = 3'd0;
        end
        consec_next_s = 1'b0;
        if (state_r == LOCK) begin
          error_next_s = 1'b1;
          state_next_s = HUNT;
        end else begin
          error_next_s = 1'b0;
        end
      end
    end else begin
      pos_next_s = pos_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_r  <= HUNT;
      pos_r    <= 3'd0;
      match_r  <= 1'b0;
      error_r  <= 1'b0;
      consec_r <= 1'b0;
      cnt_r    <= '0;
    end else begin
      state_r  <= state_next_s;
      pos_r    <= pos_next_s;
      match_r  <= match_next_s;
      error_r  <= error_next_s;
      consec_r <= consec_next_s;
      cnt_r    <= cnt_next_s;
    end
  end

  assign pos_o       = pos_r;
  assign expected_o  = exp_digit_s;
  assign match_o     = match_r;
  assign error_o     = error_r;
  assign lock_o      = (state_r == LOCK);
  assign match_cnt_o = cnt_r;

endmodule
